// File: rtl/alu_cmd_sequencer.sv
// Host-side driver for the ALU start/done handshake: buffers commands in a small FIFO,
// runs one ALU operation at a time with a completion timeout, and returns one response per command.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [2:0]    OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [18:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q;
    logic [2:0]    op_q, op_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [15:0]   res_q, res_d;
    logic [2:0]    rop_q, rop_d;
    logic          err_q, err_d, to_q, to_d;
    logic          full, empty, push, pop, done_rise;
    logic [18:0]   head;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign done_rise = alu_done && !done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            rop_q    <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q   <= cnt_d;
            done_q  <= alu_done;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rop_q   <= rop_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rop_d   = rop_q;
        err_d   = err_q;
        to_d    = to_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head[18:16] == OP_ILLEGAL) begin
                        res_d   = '0;
                        rop_d   = OP_ILLEGAL;
                        err_d   = 1'b1;
                        to_d    = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        op_d    = head[18:16];
                        a_d     = head[15:8];
                        b_d     = head[7:0];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done edge on the last counted cycle still counts as completion.
                if (done_rise) begin
                    res_d   = alu_result;
                    rop_d   = op_q;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == LAST_CNT) begin
                    res_d   = '0;
                    rop_d   = op_q;
                    err_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = !full;
    assign alu_start   = (state_q == S_ISSUE);
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = res_q;
    assign rsp_op      = rop_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side driver for the ALU start/done protocol; it is the master that drives alu_top's start, op, in_a and in_b, and collects done and result. It accepts commands on a valid/ready stream and buffers them in a small FIFO. It issues one ALU operation at a time, waits for completion with a timeout, and returns each result on a valid/ready response stream. It sits between the host/command bus and alu_top.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 64, max WAIT cycles before abandoning an operation (>=2)
CW, 8, wait-counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  3  ALU opcode
cmd_a  in  8  operand A
cmd_b  in  8  operand B
alu_start  out  1  one-cycle start pulse to ALU
alu_op  out  3  opcode to ALU, held stable from ISSUE until leaving WAIT
alu_a  out  8  operand A to ALU, held likewise
alu_b  out  8  operand B to ALU, held likewise
alu_done  in  1  ALU completion
alu_result  in  16  ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result
rsp_op  out  3  opcode of this response
rsp_err  out  1  illegal opcode (3'b111), not issued
rsp_timeout  out  1  ALU did not complete in TIMEOUT cycles
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM IDLE, wait counter 0, done_q 0. All outputs 0 except cmd_ready, which is 1.
- Push: cmd_valid & cmd_ready at a rising edge writes the command. When full, cmd_ready=0 and no push occurs, even if a pop happens in the same cycle.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: if FIFO non-empty, pop the head.
  - Legal op (000-110): latch it into alu_op/a/b and go to ISSUE.
  - op=111: load rsp_result=0, rsp_err=1, rsp_op=111 and go to RESP. No alu_start is issued.
- ISSUE: alu_start=1 for exactly this one cycle. Clear the wait counter and go to WAIT.
- WAIT: alu_start=0; the counter increments each cycle.
  - Completion is the rising edge of alu_done (alu_done & ~done_q, where done_q is registered every cycle in all states). A done level left over from a prior operation is not completion.
  - On completion: capture alu_result into rsp_result, set rsp_op=alu_op, clear err/timeout, and go to RESP.
  - If the counter reaches TIMEOUT-1 with no completion: rsp_result=0, rsp_timeout=1, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: rsp_valid=1, and response fields are held stable until rsp_ready=1 at a rising edge. Then rsp_valid drops and the FSM returns to IDLE.
- Minimum spacing between successive alu_start pulses is 4 cycles: IDLE, ISSUE, WAIT (at least 1), RESP.
- Latency: first command pushed at edge N into an empty, idle block gives alu_start high during cycle N+2.
- A late alu_done after a timeout is ignored; done_q continues tracking it.
- Commands are processed strictly in FIFO order. Exactly one response is produced per accepted command.
- Reset asserted mid-operation: the in-flight command and all FIFO contents are discarded and no response is produced. alu_start falls immediately.

Test Plan:
- Reset, then push op=000 A=25 B=17; ALU model asserts done 3 cycles after start with result 42 -> one alu_start pulse, rsp_valid with rsp_result=42, rsp_op=000, err=0, timeout=0.
- Push 5 commands back-to-back (SUB 42,15; MUL 6,9; DIV 100,4; AND AA,CC; OR AA,CC) with rsp_ready=1 -> cmd_ready falls after 4 are stored; responses are 27, 54, 25, 0x88, 0xEE in order.
- Push op=111 A=1 B=2 -> no alu_start; response rsp_err=1, rsp_result=0, rsp_op=111.
- ALU model never asserts done, TIMEOUT=8 -> rsp_timeout=1, result 0, 8 cycles after ISSUE. A done pulse injected afterwards produces no extra response.
- Hold rsp_ready=0 for 10 cycles after XOR AA,CC completes -> rsp_valid and rsp_result=0x66 stay stable and no new alu_start occurs. Raise rsp_ready -> one handshake, then the next command issues.
- Assert reset during WAIT with 2 commands queued -> all outputs clear asynchronously, cmd_ready=1, no responses after release, busy=0.
